// File: rtl/occ_pkg.sv
// Shared types and helpers for the multi-door occupancy counter.
package occ_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_SEEN = 2'd1,
        IN_SEEN  = 2'd2,
        HOLD     = 2'd3
    } door_state_e;

    function automatic int presc_width(input int clk_hz, input int tick_hz);
        return (clk_hz / tick_hz > 1) ? $clog2(clk_hz / tick_hz) : 1;
    endfunction

    function automatic int clamp(input int value, input int lo, input int hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/door_direction_fsm.sv
// One door: sensor synchronisers, rising-edge detect, timeout timer and direction FSM.
module door_direction_fsm
    import occ_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned HOLD_TICKS    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sens_out,
    input  logic sens_in,
    input  logic tick,
    output logic enter_pulse,
    output logic exit_pulse
);

    localparam int unsigned MAX_TICKS = (TIMEOUT_TICKS > HOLD_TICKS) ? TIMEOUT_TICKS : HOLD_TICKS;
    localparam int unsigned TMR_W     = $clog2(MAX_TICKS + 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_TICKS - 1);

    // [0] first sync flop, [1] second sync flop, [2] previous-value edge register
    logic [2:0]       out_q, in_q;
    logic             rise_out, rise_in;
    door_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             enter_q, enter_d, exit_q, exit_d;

    // Reset to 1 so a sensor already high at reset release produces no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 3'b111;
            in_q  <= 3'b111;
        end else begin
            out_q <= {out_q[1:0], sens_out};
            in_q  <= {in_q[1:0], sens_in};
        end
    end

    assign rise_out = out_q[1] & ~out_q[2];
    assign rise_in  = in_q[1] & ~in_q[2];

    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise_out && !rise_in) begin
                    state_d = OUT_SEEN;
                end else if (rise_in && !rise_out) begin
                    state_d = IN_SEEN;
                end
            end
            OUT_SEEN: begin
                if (rise_in) begin
                    state_d = HOLD;
                    enter_d = 1'b1;
                end else if (tick && timer_q == TO_LAST) begin
                    state_d = IDLE;
                end
            end
            IN_SEEN: begin
                if (rise_out) begin
                    state_d = HOLD;
                    exit_d  = 1'b1;
                end else if (tick && timer_q == TO_LAST) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (tick && timer_q == HOLD_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q || state_q == IDLE) begin
            timer_d = '0;
        end else if (tick) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    assign enter_pulse = enter_q;
    assign exit_pulse  = exit_q;

endmodule

// File: rtl/occupancy_counter_mc.sv
// Multi-door occupancy counter: shared tick prescaler, per-door direction FSMs and a
// saturating head-count accumulator with capacity and underflow flags.
module occupancy_counter_mc
    import occ_pkg::*;
#(
    parameter int unsigned N_DOORS       = 2,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned CAPACITY      = 40,
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned TICK_HZ       = 10,
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned HOLD_TICKS    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DOORS-1:0] sens_out,
    input  logic [N_DOORS-1:0] sens_in,
    input  logic               clear,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               over_cap,
    output logic               empty,
    output logic [N_DOORS-1:0] enter_pulse,
    output logic [N_DOORS-1:0] exit_pulse,
    output logic               err_underflow
);

    localparam int PRESC_DIV = int'(CLK_HZ / TICK_HZ);
    localparam int PRESC_W   = presc_width(int'(CLK_HZ), int'(TICK_HZ));
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic [PRESC_W-1:0]      presc_q;
    logic                    tick;
    logic signed [CNT_W+3:0] delta;
    int                      next_val;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    err_q;

    assign tick = (presc_q == PRESC_W'(PRESC_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    for (genvar d = 0; d < N_DOORS; d++) begin : g_door
        door_direction_fsm #(
            .TIMEOUT_TICKS(TIMEOUT_TICKS),
            .HOLD_TICKS   (HOLD_TICKS)
        ) u_door (
            .clk        (clk),
            .rst_n      (rst_n),
            .sens_out   (sens_out[d]),
            .sens_in    (sens_in[d]),
            .tick       (tick),
            .enter_pulse(enter_pulse[d]),
            .exit_pulse (exit_pulse[d])
        );
    end

    always_comb begin
        delta = '0;
        for (int i = 0; i < N_DOORS; i++) begin
            delta = delta + $signed({{(CNT_W + 3){1'b0}}, enter_pulse[i]})
                          - $signed({{(CNT_W + 3){1'b0}}, exit_pulse[i]});
        end
        next_val = int'(count_q) + int'(delta);
        count_d  = CNT_W'(clamp(next_val, 0, CNT_MAX));
    end

    // clear wins over a same-cycle delta, which is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (next_val < 0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign count         = count_q;
    assign err_underflow = err_q;
    assign full          = (count_q >= CNT_W'(CAPACITY));
    assign over_cap      = (count_q > CNT_W'(CAPACITY));
    assign empty         = (count_q == '0);

endmodule

// File: tb/tb_occupancy_counter_mc.sv
// Directed plus randomised crossings against an arithmetic head-count model.
module tb_occupancy_counter_mc;

    localparam int N_DOORS  = 2;
    localparam int CNT_W    = 4;
    localparam int CAPACITY = 10;
    localparam int CNT_MAX  = 15;
    localparam int SETTLE   = 35;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_DOORS-1:0] sens_out = '0;
    logic [N_DOORS-1:0] sens_in = '0;
    logic               clear = 1'b0;
    logic [CNT_W-1:0]   count;
    logic               full, over_cap, empty, err_underflow;
    logic [N_DOORS-1:0] enter_pulse, exit_pulse;

    int vectors = 0;
    int miscompares = 0;
    int occ = 0;
    bit uf = 1'b0;

    always #5 clk = ~clk;

    occupancy_counter_mc #(
        .N_DOORS      (N_DOORS),
        .CNT_W        (CNT_W),
        .CAPACITY     (CAPACITY),
        .CLK_HZ       (1000),
        .TICK_HZ      (100),
        .TIMEOUT_TICKS(5),
        .HOLD_TICKS   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sens_out     (sens_out),
        .sens_in      (sens_in),
        .clear        (clear),
        .count        (count),
        .full         (full),
        .over_cap     (over_cap),
        .empty        (empty),
        .enter_pulse  (enter_pulse),
        .exit_pulse   (exit_pulse),
        .err_underflow(err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_apply(input logic [N_DOORS-1:0] ent, input logic [N_DOORS-1:0] ext);
        occ = occ + $countones(ent) - $countones(ext);
        if (occ < 0) begin
            occ = 0;
            uf  = 1'b1;
        end
        if (occ > CNT_MAX) occ = CNT_MAX;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, count, occ);
        check({tag, ".empty"}, empty, occ == 0);
        check({tag, ".full"}, full, occ >= CAPACITY);
        check({tag, ".over_cap"}, over_cap, occ > CAPACITY);
        check({tag, ".err_underflow"}, err_underflow, uf);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".pulses"}, {enter_pulse, exit_pulse}, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        occ = 0;
        uf  = 1'b0;
        check_state("clear");
    endtask

    // Entering doors trip outer then inner; exiting doors the reverse, `gap` cycles apart.
    task automatic crossing(input string tag, input logic [N_DOORS-1:0] ent,
                            input logic [N_DOORS-1:0] ext, input int gap, input int settle,
                            input bit counted);
        sens_out = sens_out | ent;
        sens_in  = sens_in | ext;
        step(gap);
        check_quiet({tag, ".gap"});
        sens_in  = sens_in | ent;
        sens_out = sens_out | ext;
        step(3);
        if (counted) begin
            check({tag, ".enter"}, enter_pulse, ent);
            check({tag, ".exit"}, exit_pulse, ext);
        end else begin
            check_quiet({tag, ".ignored"});
        end
        step(1);
        check_quiet({tag, ".after"});
        if (counted) model_apply(ent, ext);
        check_state(tag);
        sens_out = '0;
        sens_in  = '0;
        step(settle);
    endtask

    initial begin
        logic [N_DOORS-1:0] ent, ext;
        int r;

        step(3);
        check_state("reset");
        check_quiet("reset");
        rst_n = 1'b1;
        step(2);

        crossing("enter_d0", 2'b01, 2'b00, 20, SETTLE, 1'b1);
        crossing("exit_d1", 2'b00, 2'b10, 12, SETTLE, 1'b1);
        crossing("exit_at_zero", 2'b00, 2'b10, 7, SETTLE, 1'b1);
        do_clear();

        // Outer then inner 70 cycles later: outer times out, inner opens an exit.
        sens_out[0] = 1'b1;
        step(70);
        check_quiet("timeout.wait");
        sens_in[0] = 1'b1;
        repeat (6) begin
            step(1);
            check_quiet("timeout.late_in");
        end
        sens_out[0] = 1'b0;
        step(5);
        sens_out[0] = 1'b1;
        step(3);
        check("timeout.in_seen_exit", exit_pulse, 2'b01);
        step(1);
        model_apply(2'b00, 2'b01);
        check_state("timeout");
        sens_out = '0;
        sens_in  = '0;
        step(SETTLE);
        do_clear();

        repeat (16) begin
            ent = '0;
            ext = '0;
            for (int d = 0; d < N_DOORS; d++) begin
                r = $urandom_range(0, 2);
                if (r == 1) ent[d] = 1'b1;
                else if (r == 2) ext[d] = 1'b1;
            end
            if (ent == '0 && ext == '0) ent[0] = 1'b1;
            crossing("rand", ent, ext, $urandom_range(1, 35), SETTLE, 1'b1);
        end

        do_clear();
        while (occ < 9) begin
            ent = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            crossing("fill", ent, 2'b00, $urandom_range(1, 35), SETTLE, 1'b1);
        end
        while (occ < CNT_MAX) begin
            crossing("both_enter", 2'b11, 2'b00, $urandom_range(1, 35), SETTLE, 1'b1);
        end
        crossing("saturate", 2'b01, 2'b00, 9, SETTLE, 1'b1);

        // Both sensors of door 0 in the same cycle stay ambiguous.
        sens_out[0] = 1'b1;
        sens_in[0]  = 1'b1;
        repeat (8) begin
            step(1);
            check_quiet("simultaneous");
        end
        sens_out = '0;
        sens_in  = '0;
        step(SETTLE);
        check_state("simultaneous");

        do_clear();
        crossing("hold.first", 2'b01, 2'b00, 10, 1, 1'b1);
        crossing("hold.inside", 2'b01, 2'b00, 2, SETTLE, 1'b0);
        crossing("hold.after", 2'b01, 2'b00, 2, SETTLE, 1'b1);

        // Reset mid-crossing with both sensors held high through release.
        sens_out[0] = 1'b1;
        step(10);
        rst_n = 1'b0;
        sens_in[0] = 1'b1;
        step(2);
        occ = 0;
        uf  = 1'b0;
        check_state("mid_reset");
        rst_n = 1'b1;
        repeat (10) begin
            step(1);
            check_quiet("post_reset");
        end
        check_state("post_reset");
        sens_out = '0;
        sens_in  = '0;
        step(SETTLE);
        crossing("post_reset_enter", 2'b01, 2'b00, 15, SETTLE, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
